// File: rtl/seg_disp_pkg.sv
// Shared constants for the seven-segment display multiplexer: register map,
// CTRL bit positions and the active-low gfedcba hex glyph table.
package seg_disp_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_BLINK  = 1;
  localparam int REG_DIGIT0 = 2;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_DEC   = 1;
  localparam int CTRL_BLINK = 2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the glyph for nibble n; listed from F down to 0.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_disp_decode.sv
// Per-digit pattern generator: hex glyph or raw segments, forced dark when blanked.
module seg_disp_decode
  import seg_disp_pkg::*;
(
  input  logic [6:0] value,
  input  logic       decode,
  input  logic       blank,
  output logic [6:0] pattern
);

  // Select blank, hex glyph or inverted raw segments.
  always_comb begin
    pattern = SEG_BLANK;
    if (blank) begin
      pattern = SEG_BLANK;
    end else if (decode) begin
      pattern = HEX_TABLE[value[3:0]];
    end else begin
      pattern = ~value;
    end
  end

endmodule

// File: rtl/seg_disp_mux.sv
// Avalon-MM seven-segment controller with static and scanned outputs and blink.
// Define SEG_DISP_DP_EN to add per-digit decimal points (DIGIT bit 7, dp_n, seg_dp_n).
module seg_disp_mux
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000,
  parameter int ADDR_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] hex_n,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   digit_sel
`ifdef SEG_DISP_DP_EN
  ,
  output logic [NUM_DIGITS-1:0]   dp_n,
  output logic                    seg_dp_n
`endif
);

`ifdef SEG_DISP_DP_EN
  localparam int DW = 8;
`else
  localparam int DW = 7;
`endif
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [2:0]            ctrl_r;
  logic [NUM_DIGITS-1:0] mask_r;
  logic [DW-1:0]         digit_r [NUM_DIGITS];
  logic [SCAN_W-1:0]     scan_cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [BLINK_W-1:0]    blink_cnt_r;
  logic                  phase_r;
  logic [6:0]            pat_s [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_s;
  logic [DW-1:0]         rd_digit_s;
  logic                  wr_s;
  logic                  enable_s;
  logic                  blink_run_s;
  logic                  unused_wdata_s;

  assign wr_s           = chipselect && !write_n;
  assign enable_s       = ctrl_r[CTRL_EN];
  assign blink_run_s    = ctrl_r[CTRL_EN] && ctrl_r[CTRL_BLINK];
  assign unused_wdata_s = ^writedata[31:DW];

  // Register file writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_r <= 3'b000;
      mask_r <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_r[i] <= '0;
    end else if (wr_s) begin
      if (address == ADDR_W'(REG_CTRL)) ctrl_r <= writedata[2:0];
      if (address == ADDR_W'(REG_BLINK)) mask_r <= writedata[NUM_DIGITS-1:0];
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (address == ADDR_W'(REG_DIGIT0 + i)) digit_r[i] <= writedata[DW-1:0];
      end
    end
  end

  // Zero-wait-state read mux; unmapped addresses fall through to zero.
  always_comb begin
    rd_digit_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      rd_digit_s = rd_digit_s |
                   ((address == ADDR_W'(REG_DIGIT0 + i)) ? digit_r[i] : {DW{1'b0}});
    end
    if (address == ADDR_W'(REG_CTRL)) begin
      readdata = {29'h0, ctrl_r};
    end else if (address == ADDR_W'(REG_BLINK)) begin
      readdata = {{(32-NUM_DIGITS){1'b0}}, mask_r};
    end else begin
      readdata = {{(32-DW){1'b0}}, rd_digit_s};
    end
  end

  // Scan prescaler and digit index; held at zero while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_r <= '0;
      idx_r      <= '0;
    end else if (!enable_s) begin
      scan_cnt_r <= '0;
      idx_r      <= '0;
    end else if (scan_cnt_r == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_r <= '0;
      idx_r      <= (idx_r == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_r + 1'b1;
    end else begin
      scan_cnt_r <= scan_cnt_r + 1'b1;
    end
  end

  // Blink prescaler and phase; cleared whenever blinking is not active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (!blink_run_s) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (blink_cnt_r == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_r <= '0;
      phase_r     <= ~phase_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign blank_s[i] = !enable_s || (ctrl_r[CTRL_BLINK] && mask_r[i] && phase_r);
    seg_disp_decode u_decode (
      .value   (digit_r[i][6:0]),
      .decode  (ctrl_r[CTRL_DEC]),
      .blank   (blank_s[i]),
      .pattern (pat_s[i])
    );
  end

  // Static and scanned output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_n     <= '1;
      seg_n     <= SEG_BLANK;
      digit_sel <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) hex_n[7*i +: 7] <= pat_s[i];
      seg_n     <= pat_s[idx_r];
      digit_sel <= enable_s ? (NUM_DIGITS'(1) << idx_r) : '0;
    end
  end

`ifdef SEG_DISP_DP_EN
  // Decimal points share blanking and latency with the segments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_n     <= '1;
      seg_dp_n <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) dp_n[i] <= blank_s[i] | ~digit_r[i][7];
      seg_dp_n <= blank_s[idx_r] | ~digit_r[idx_r][7];
    end
  end
`endif

endmodule

// File: tb/tb_seg_disp_mux.sv
// Self-checking bench for seg_disp_mux: cycle-level reference model plus directed
// and randomized bus traffic. Honours SEG_DISP_DP_EN like the design.
module tb_seg_disp_mux;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BD = 8;
`ifdef SEG_DISP_DP_EN
  localparam logic [7:0] DMASK = 8'hFF;
`else
  localparam logic [7:0] DMASK = 8'h7F;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = 4'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [27:0] hex_n;
  logic [6:0]  seg_n;
  logic [3:0]  digit_sel;
`ifdef SEG_DISP_DP_EN
  logic [3:0]  dp_n;
  logic        seg_dp_n;
`endif

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  seg_disp_mux #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_DIV(BD), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .hex_n(hex_n), .seg_n(seg_n), .digit_sel(digit_sel)
`ifdef SEG_DISP_DP_EN
    , .dp_n(dp_n), .seg_dp_n(seg_dp_n)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: registers plus counts of enabled clock edges.
  logic [2:0]  m_ctrl;
  logic [3:0]  m_mask;
  logic [7:0]  m_digit [N];
  int          m_k;
  int          m_b;
  logic [27:0] e_hex;
  logic [6:0]  e_seg;
  logic [3:0]  e_sel;
  logic [3:0]  e_dp;
  logic        e_segdp;

  function automatic logic [6:0] hex_lut(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic int cur_idx();
    return (m_k / SD) % N;
  endfunction

  function automatic int cur_phase();
    return (m_b / BD) % 2;
  endfunction

  function automatic logic m_blank(input int i);
    return !m_ctrl[0] || (m_ctrl[2] && m_mask[i] && (cur_phase() == 1));
  endfunction

  function automatic logic [6:0] m_pat(input int i);
    if (m_blank(i)) return 7'h7F;
    if (m_ctrl[1]) return hex_lut(m_digit[i][3:0]);
    return ~m_digit[i][6:0];
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (a == 4'd0) return {29'd0, m_ctrl};
    if (a == 4'd1) return {28'd0, m_mask};
    if (a >= 4'd2 && a < 4'd6) return {24'd0, m_digit[a - 4'd2]};
    return 32'd0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ctrl <= 3'd0;
      m_mask <= 4'd0;
      for (int i = 0; i < N; i++) m_digit[i] <= 8'd0;
      m_k <= 0;
      m_b <= 0;
      e_hex <= {28{1'b1}};
      e_seg <= 7'h7F;
      e_sel <= 4'd0;
      e_dp <= 4'hF;
      e_segdp <= 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        e_hex[7*i +: 7] <= m_pat(i);
        e_dp[i] <= m_blank(i) | ~m_digit[i][7];
      end
      e_seg <= m_pat(cur_idx());
      e_segdp <= m_blank(cur_idx()) | ~m_digit[cur_idx()][7];
      e_sel <= m_ctrl[0] ? (4'd1 << cur_idx()) : 4'd0;
      m_k <= m_ctrl[0] ? (m_k + 1) % (SD * N) : 0;
      m_b <= (m_ctrl[0] && m_ctrl[2]) ? (m_b + 1) % (2 * BD) : 0;
      if (chipselect && !write_n) begin
        if (address == 4'd0) m_ctrl <= writedata[2:0];
        else if (address == 4'd1) m_mask <= writedata[3:0];
        else if (address >= 4'd2 && address < 4'd6)
          m_digit[address - 4'd2] <= writedata[7:0] & DMASK;
      end
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("hex_n", hex_n, e_hex);
      check("seg_n", seg_n, e_seg);
      check("digit_sel", digit_sel, e_sel);
      check("readdata", readdata, m_read(address));
`ifdef SEG_DISP_DP_EN
      check("dp_n", dp_n, e_dp);
      check("seg_dp_n", seg_dp_n, e_segdp);
`endif
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic next_out();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_sel(input logic [3:0] v, input int budget);
    int n = 0;
    @(negedge clk);
    while (digit_sel !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_digit_sel", digit_sel, v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] v0;
    logic [6:0] exp_seg [4];
    int n;
    exp_seg[0] = 7'h40; exp_seg[1] = 7'h79; exp_seg[2] = 7'h00; exp_seg[3] = 7'h0E;

    repeat (2) @(posedge clk);
    #1;
    check("rst_hex", hex_n, {28{1'b1}});
    check("rst_seg", seg_n, 7'h7F);
    check("rst_sel", digit_sel, 4'd0);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    // Hex decode on the static bus and the scan sequence.
    wr(4'd0, 32'd3);
    wr(4'd2, 32'd0); wr(4'd3, 32'd1); wr(4'd4, 32'd8); wr(4'd5, 32'hF);
    next_out();
    check("t2_hex", hex_n, {7'h0E, 7'h00, 7'h79, 7'h40});
    n = 0;
    while (digit_sel === 4'd1 && n < 40) begin @(negedge clk); n++; end
    wait_sel(4'd1, 40);
    for (int j = 0; j < 5; j++) begin
      check("t2_scan_sel", digit_sel, 4'd1 << (j % 4));
      check("t2_scan_seg", seg_n, exp_seg[j % 4]);
      repeat (4) @(negedge clk);
    end

    // Raw mode and readback.
    wr(4'd0, 32'd1);
    wr(4'd4, 32'h3F);
    next_out();
    check("t3_raw_hex2", hex_n[20:14], 7'h40);
    address = 4'd4; #1;
    check("t3_read4", readdata, 32'h3F);
    address = 4'd9; #1;
    check("t3_read9", readdata, 32'h0);

    // Blink on digit 1.
    wr(4'd0, 32'd7);
    wr(4'd1, 32'd2);
    @(negedge clk);
    v0 = hex_n[13:7];
    n = 0;
    while (hex_n[13:7] === v0 && n < 40) begin @(negedge clk); n++; end
    check("t4_first_blank", hex_n[13:7], 7'h7F);
    for (int h = 1; h <= 4; h++) begin
      repeat (8) @(negedge clk);
      check("t4_blink_d1", hex_n[13:7], (h % 2 == 1) ? 7'h79 : 7'h7F);
      check("t4_steady_d0", hex_n[6:0], 7'h40);
    end
    wr(4'd0, 32'd3);
    next_out();
    check("t4_blink_off", hex_n[13:7], 7'h79);

    // Disable while digit 2 is selected, then re-enable.
    wait_sel(4'b0100, 40);
    address = 4'd0; writedata = 32'd0; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1;
    next_out();
    check("t5_off_sel", digit_sel, 4'd0);
    check("t5_off_seg", seg_n, 7'h7F);
    wr(4'd0, 32'd3);
    next_out();
    check("t5_on_sel", digit_sel, 4'd1);
    check("t5_on_seg", seg_n, 7'h40);

    // Decimal point bit.
    wr(4'd5, 32'h80);
    next_out();
`ifdef SEG_DISP_DP_EN
    check("t6_dp3", dp_n[3], 1'b0);
    check("t6_hex3", hex_n[27:21], 7'h40);
`else
    address = 4'd5; #1;
    check("t6_read5", readdata, 32'h0);
`endif

    // Asynchronous reset in the middle of a scan.
    wait_sel(4'b0100, 40);
    #2 reset = 1'b1;
    #1;
    check("t1_hex", hex_n, {28{1'b1}});
    check("t1_seg", seg_n, 7'h7F);
    check("t1_sel", digit_sel, 4'd0);
    @(posedge clk); @(posedge clk); #2 reset = 1'b0;
    for (int a = 0; a < 6; a++) begin
      address = 4'(a); #1;
      check("t1_read_zero", readdata, 32'h0);
    end

    // Randomized bus traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      address = 4'($urandom_range(0, 15));
      writedata = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        chipselect = ($urandom_range(0, 3) != 0);
        write_n = 1'b0;
        if (address == 4'd0) writedata[0] = ($urandom_range(0, 3) != 0);
      end else begin
        chipselect = 1'($urandom_range(0, 1));
        write_n = 1'b1;
      end
    end
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
